// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V core: datapath width, the
// special instruction encodings the fetch stage cares about, the fetch FSM
// state type and the IF/ID payload that decode also consumes.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Redirect targets are forced onto a word boundary; low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory
// (slave). The read is combinational: data follows the address in-cycle.
interface if_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble beats load, load beats hold; a bubble is
// the canonical empty slot (pc 0, NOP encoding, not valid).
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output if_id_t          if_id_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;
    if_id_t bubble_val;

    assign bubble_val = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    // Choose the next IF/ID contents from the bubble/load controls.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble_i) begin
            if_id_d = bubble_val;
        end else if (load_i) begin
            if_id_d = '{pc: pc_i, instr: instr_i, valid: 1'b1};
        end
    end

    // Register the payload; reset empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= bubble_val;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills the
// IF/ID register and stops fetching after an ECALL so a bench can spot the
// end of a program. Redirects beat stalls, stalls beat normal fetch.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    if_stage_if.master      imem,
    output logic [XLEN-1:0] pc_f_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            halted_o,
    output logic [31:0]     fetch_count_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            halted_q, halted_d;
    logic            ifid_load;
    logic            ifid_bubble;
    logic            is_halt_instr;
    if_id_t          if_id;

    assign is_halt_instr = (imem.imem_rdata == HALT_INSTR);

    // Next-state logic for the fetch FSM, PC, counter and IF/ID controls.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        halted_d      = halted_q;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;

        case (state_q)
            FETCH_BOOT: begin
                // Settling cycle after reset: stall is ignored, a redirect
                // still moves the PC.
                ifid_bubble = 1'b1;
                state_d     = FETCH_RUN;
                halted_d    = 1'b0;
                if (redirect_i) begin
                    pc_d = align_pc(redirect_pc_i);
                end
            end

            FETCH_RUN: begin
                if (redirect_i) begin
                    pc_d        = align_pc(redirect_pc_i);
                    ifid_bubble = 1'b1;
                end else if (!stall_i) begin
                    ifid_load     = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (is_halt_instr) begin
                        // ECALL is kept in IF/ID; PC parks on it.
                        state_d  = FETCH_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end

            FETCH_HALT: begin
                if (redirect_i) begin
                    // The ECALL was on a wrong path; resume fetching.
                    pc_d        = align_pc(redirect_pc_i);
                    ifid_bubble = 1'b1;
                    state_d     = FETCH_RUN;
                    halted_d    = 1'b0;
                end else if (!stall_i) begin
                    ifid_bubble = 1'b1;
                end
            end

            default: begin
                state_d     = FETCH_BOOT;
                halted_d    = 1'b0;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // Fetch FSM state, PC, fetch counter and halt flag, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc_i     (pc_q),
        .instr_i  (imem.imem_rdata),
        .if_id_o  (if_id)
    );

    assign imem.imem_addr = pc_q;
    assign pc_f_o         = pc_q;
    assign if_id_pc_o     = if_id.pc;
    assign if_id_instr_o  = if_id.instr;
    assign if_id_valid_o  = if_id.valid;
    assign halted_o       = halted_q;
    assign fetch_count_o  = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage: boot, free-run, stall, flush-over-stall,
// ECALL halt and resume, PC and counter wrap, and reset out of HALT.
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        stallIn;
    logic        redirectIn;
    logic [31:0] redirectPc;
    logic [31:0] pcF;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdInstr;
    logic        ifIdValid;
    logic        halted;
    logic [31:0] fetchCount;
    logic        ecallEn;
    logic [31:0] memWord;
    int          checks;
    int          errors;

    if_stage_if imemBus ();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stallIn),
        .redirect_i    (redirectIn),
        .redirect_pc_i (redirectPc),
        .imem          (imemBus),
        .pc_f_o        (pcF),
        .if_id_pc_o    (ifIdPc),
        .if_id_instr_o (ifIdInstr),
        .if_id_valid_o (ifIdValid),
        .halted_o      (halted),
        .fetch_count_o (fetchCount)
    );

    // Clock generation, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: one addi at 0, optional ECALL at 0x24,
    // NOPs everywhere else.
    always_comb begin
        memWord = 32'h0000_0013;
        if (imemBus.imem_addr == 32'h0000_0000) memWord = 32'h00A0_0093;
        if (ecallEn && imemBus.imem_addr == 32'h0000_0024) memWord = 32'h0000_0073;
    end
    assign imemBus.imem_rdata = memWord;

    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        rst        = r;
        stallIn    = s;
        redirectIn = rd;
        redirectPc = rpc;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkStage(input string tag, input logic [31:0] expPc, input logic [31:0] expIfIdPc,
                              input logic [31:0] expInstr, input logic expValid,
                              input logic [31:0] expCount, input logic expHalted);
        checkOutput({tag, ".pc"},     pcF,                expPc);
        checkOutput({tag, ".idpc"},   ifIdPc,             expIfIdPc);
        checkOutput({tag, ".instr"},  ifIdInstr,          expInstr);
        checkOutput({tag, ".valid"},  {31'd0, ifIdValid}, {31'd0, expValid});
        checkOutput({tag, ".count"},  fetchCount,         expCount);
        checkOutput({tag, ".halted"}, {31'd0, halted},    {31'd0, expHalted});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ecallEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        checkStage("reset", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);

        // Boot cycle, then free-run from address 0.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("boot", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
        stepCycle();
        checkStage("fetch0", 32'h4, 32'h0, 32'h00A00093, 1'b1, 32'd1, 1'b0);
        stepCycle();
        checkStage("fetch4", 32'h8, 32'h4, 32'h13, 1'b1, 32'd2, 1'b0);
        stepCycle();
        checkOutput("fetch8.pc", pcF, 32'hC);
        stepCycle();
        checkStage("fetchC", 32'h10, 32'hC, 32'h13, 1'b1, 32'd4, 1'b0);

        // Three stalled cycles at PC 0x10.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkStage("stall", 32'h10, 32'hC, 32'h13, 1'b1, 32'd4, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("unstall", 32'h14, 32'h10, 32'h13, 1'b1, 32'd5, 1'b0);

        // Run into the ECALL at 0x24.
        ecallEn = 1'b1;
        stepCycle();
        stepCycle();
        stepCycle();
        stepCycle();
        checkStage("pre_ecall", 32'h24, 32'h20, 32'h13, 1'b1, 32'd9, 1'b0);
        stepCycle();
        checkStage("ecall", 32'h24, 32'h24, 32'h73, 1'b1, 32'd10, 1'b1);
        stepCycle();
        checkStage("halt_bubble", 32'h24, 32'h0, 32'h13, 1'b0, 32'd10, 1'b1);

        // Redirect out of HALT to 0x30.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h30);
        stepCycle();
        checkStage("resume", 32'h30, 32'h0, 32'h13, 1'b0, 32'd10, 1'b0);
        ecallEn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("fetch30", 32'h34, 32'h30, 32'h13, 1'b1, 32'd11, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("at40.pc", pcF, 32'h40);

        // Redirect together with stall: flush wins, low bits cleared.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h203);
        stepCycle();
        checkStage("flush_stall", 32'h200, 32'h0, 32'h13, 1'b0, 32'd14, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("fetch200", 32'h204, 32'h200, 32'h13, 1'b1, 32'd15, 1'b0);

        // PC wrap at the top of the address space, and counter wrap.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("top.pc", pcF, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        stepCycle();
        checkStage("wrap", 32'h0, 32'hFFFF_FFFC, 32'h13, 1'b1, 32'd0, 1'b0);

        // Halt again, then reset while halted.
        ecallEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h24);
        stepCycle();
        checkOutput("to24.pc", pcF, 32'h24);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("ecall2", 32'h24, 32'h24, 32'h73, 1'b1, 32'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("halt_reset", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkStage("reboot", 32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined RISC-V core, directly upstream of decode. It owns the PC register and drives the instruction-memory address. It latches the fetched word into the IF/ID pipeline register and honours stall and flush/redirect requests from the hazard unit and the EX stage. A small FSM stops fetching after an ECALL, so benches can detect program end without a fixed run time.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
HALT_INSTR, 32'h0000_0073, encoding that halts fetch (ECALL)

Ports:
clk  in  1  core clock, all state updates on its rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC and IF/ID (load-use hazard from the hazard unit)
redirect_i  in  1  taken branch/jump resolved in EX
redirect_pc_i  in  XLEN  target PC for the redirect
imem_addr_o  out  XLEN  byte address to instruction memory, equal to PC
imem_rdata_i  in  32  instruction word, combinational read of imem_addr_o
pc_f_o  out  XLEN  current fetch PC, for monitors
if_id_pc_o  out  XLEN  PC of the instruction held in IF/ID
if_id_instr_o  out  32  instruction held in IF/ID
if_id_valid_o  out  1  IF/ID holds a real instruction
halted_o  out  1  FSM is in HALT
fetch_count_o  out  32  number of valid instructions written into IF/ID

Behaviour:
- Reset (rst high at a posedge) has priority over everything:
  - PC <= RESET_PC; if_id_pc_o <= 0; if_id_instr_o <= NOP_INSTR; if_id_valid_o <= 0.
  - fetch_count_o <= 0; FSM <= BOOT; halted_o = 0.
- Reset asserted mid-run aborts all state; there is no partial update.
- imem_addr_o = pc_f_o = PC register, combinational; imem_rdata_i is sampled in the same cycle.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle. IF/ID is loaded with a bubble, PC holds, then the FSM moves to RUN. This gives memory one clean cycle after reset.
  - RUN: normal fetch.
  - HALT: PC frozen, IF/ID loaded with bubbles every cycle, halted_o = 1.
- Per-cycle priority in RUN and HALT is redirect_i > stall_i > normal.
- redirect_i = 1:
  - PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; the low bits are silently cleared.
  - IF/ID <= bubble (valid 0, NOP_INSTR, pc 0). The bubble is written even if stall_i is also high, because a flush overrides a stall.
  - In HALT, a redirect returns the FSM to RUN (the ECALL was on a wrong path).
  - In BOOT, a redirect is applied to PC and the FSM still moves to RUN.
- stall_i = 1 with no redirect: PC, IF/ID and fetch_count_o all hold. In BOOT, stall is ignored.
- Normal fetch in RUN:
  - PC <= PC + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
  - IF/ID <= {PC, imem_rdata_i, valid 1}; fetch_count_o increments, wrapping at 2^32.
- Halt trigger: a normal fetch in RUN with imem_rdata_i == HALT_INSTR.
  - The ECALL itself is latched into IF/ID as valid and counted.
  - PC is NOT advanced and the FSM moves to HALT on the same edge.
  - HALT_INSTR arriving while stalled or redirected does not trigger halt.
- Latency: an instruction at address A appears on the IF/ID outputs one cycle after PC == A, provided the stage is not stalled.

Decomposition:
- Shared package riscv_pkg: XLEN, NOP_INSTR, HALT_INSTR, the fetch FSM state enum, and a typedef for the IF/ID payload (pc, instr, valid). Decode uses the same payload typedef.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with load, hold and bubble controls.
- The PC, FSM and counter stay in if_stage.

Test Plan:
- Reset then free-run, with imem returning 0x00A00093 at address 0 and NOPs elsewhere:
  - BOOT cycle gives if_id_valid_o = 0.
  - Next cycle: if_id_pc_o = 0, if_id_instr_o = 0x00A00093, valid 1.
  - PC then advances 4, 8, 12, ….
- stall_i held high for 3 cycles with PC = 0x10: PC stays 0x10 and IF/ID, valid and fetch_count_o are unchanged. Release gives the next IF/ID pc = 0x10.
- redirect_i and stall_i high together with redirect_pc_i = 0x203 at PC = 0x40: next cycle PC = 0x200 and if_id_valid_o = 0.
- ECALL at 0x24:
  - IF/ID holds pc 0x24, instr 0x73, valid 1; halted_o = 1 from the next edge.
  - PC stays 0x24 and subsequent IF/ID entries are bubbles.
  - A redirect to 0x30 clears halted_o and fetch resumes at 0x30.
- PC = 0xFFFF_FFFC with normal fetch gives next PC = 0x0000_0000. fetch_count_o at 0xFFFF_FFFF wraps to 0.
- rst asserted for 1 cycle while in HALT gives PC = RESET_PC, halted_o = 0, fetch_count_o = 0, IF/ID = NOP with valid 0.
